// File: rtl/bf_bus_ctrl.sv
// -----------------------------------------------------------------------------
// bf_bus_ctrl
// Bus target for the BF interpreter core. Decodes the core's one-hot strobes
// and serves them from a shared synchronous SRAM (program and data space) or
// from two console FIFOs toward the host. Each completed transaction returns
// a one-cycle valid pulse. The core stalls until it sees valid.
//
// Ports
//   clock, reset           single rising-edge clock, async active-high reset
//   addr, val_out          core address and write data
//   read_prog .. write_io  core request strobes, exactly one high per request
//   val_in, valid          read data to core, one-cycle completion pulse
//   bus_error              sticky flag: more than one strobe seen while idle
//   mem_*                  SRAM port (read data arrives one cycle after mem_re)
//   rx_data/valid/ready    host -> core byte stream (ready/valid handshake)
//   tx_data/valid/ready    core -> host byte stream (ready/valid handshake)
// -----------------------------------------------------------------------------
module bf_bus_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] val_out,
  input  logic                  read_prog,
  input  logic                  read_data,
  input  logic                  write_data,
  input  logic                  read_io,
  input  logic                  write_io,
  output logic [DATA_WIDTH-1:0] val_in,
  output logic                  valid,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_space,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                state;
  logic                  resp_mem;   // current RESP returns SRAM read data
  logic [DATA_WIDTH-1:0] val_q;

  // FIFO state
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0]      rx_count, tx_count;
  logic                  rx_empty, tx_full;
  logic                  rx_push, rx_pop, tx_push, tx_pop;

  // ---------------------------------------------------------------------------
  // Request decode. A request is legal only with exactly one strobe high;
  // x & (x - 1) is non-zero whenever two or more bits are set.
  // ---------------------------------------------------------------------------
  logic [4:0] strobes;
  logic       multi, single, req_ok, accept;

  assign strobes = {read_prog, read_data, write_data, read_io, write_io};
  assign multi   = |(strobes & (strobes - 5'd1));
  assign single  = (|strobes) && !multi;
  assign req_ok  = (state == IDLE) && single;

  assign mem_re  = req_ok && (read_prog || read_data);
  assign mem_we  = req_ok && write_data;
  // I/O requests stall in IDLE until their FIFO can serve them.
  assign rx_pop  = req_ok && read_io  && !rx_empty;
  assign tx_push = req_ok && write_io && !tx_full;
  assign accept  = mem_re || mem_we || rx_pop || tx_push;

  assign mem_addr  = addr;
  assign mem_wdata = val_out;
  assign mem_space = read_data || write_data;

  // SRAM data is only valid in the RESP cycle, so it bypasses val_q there.
  assign val_in = (state == RESP && resp_mem) ? mem_rdata : val_q;

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered valid pulse.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= 1'b0;
      resp_mem  <= 1'b0;
      val_q     <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (multi) bus_error <= 1'b1;
          if (accept) begin
            state    <= RESP;
            valid    <= 1'b1;
            resp_mem <= mem_re;
          end
          if (rx_pop) val_q <= rx_mem[rx_rd_ptr];
        end
        RESP: begin
          state    <= IDLE;
          valid    <= 1'b0;
          resp_mem <= 1'b0;
          if (resp_mem) val_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Console FIFOs: circular buffers with an occupancy counter one bit wider
  // than the pointers, so full and empty are distinguishable.
  // ---------------------------------------------------------------------------
  assign rx_empty = (rx_count == '0);
  assign rx_ready = (rx_count != FULL_CNT);
  assign rx_push  = rx_valid && rx_ready;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_valid = (tx_count != '0);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_data  = tx_mem[tx_rd_ptr];

  // NOTE: storage arrays carry no reset; the pointers and counts define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= val_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

endmodule
